// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Quotient goes to oQ (LO) and remainder to oR (HI). Results are registered
// and held until the next accepted start.
// Optional feature macro: SEQ_DIVIDER_ABORT_EN adds an abort input that
// cancels an operation in flight without touching the held results.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation are held
// CALC  | one shift/compare/subtract step per cycle, WIDTH steps
// FIX   | apply sign correction, publish results, pulse done
// ZERO  | divisor was zero: publish the all-ones/raw-dividend result
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
`ifdef SEQ_DIVIDER_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] oQ,
  output logic [WIDTH-1:0] oR,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, ZERO} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // dvd holds the dividend magnitude; quotient bits shift in at the bottom,
  // so after WIDTH steps it holds the unsigned quotient. For a zero divisor
  // it holds the raw dividend instead, since that is what oR must return.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] oq_q, oq_d;
  logic [WIDTH-1:0] or_q, or_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   diff;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  // Next-state, datapath step and result publication.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    oq_d    = oq_q;
    or_d    = or_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    // The shifted-out remainder bit is always 0 before the last step because
    // the partial remainder never exceeds the dividend bits consumed so far.
    rem_sh = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d  = magnitude(iB, sign);
          qneg_d = sign & (iA[WIDTH-1] ^ iB[WIDTH-1]);
          rneg_d = sign & iA[WIDTH-1];
          rem_d  = '0;
          cnt_d  = CW'(WIDTH);
          if (iB == '0) begin
            dvd_d   = iA;
            state_d = ZERO;
          end else begin
            dvd_d   = magnitude(iA, sign);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (diff[WIDTH]) begin
          rem_d = rem_sh;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = diff[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        oq_d    = qneg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
        or_d    = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;
        dz_d    = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ZERO: begin
        oq_d    = '1;
        or_d    = dvd_q;
        dz_d    = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SEQ_DIVIDER_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      oq_d    = oq_q;
      or_d    = or_q;
      dz_d    = dz_q;
      done_d  = 1'b0;
    end
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      oq_q    <= '0;
      or_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      oq_q    <= oq_d;
      or_q    <= or_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign oQ       = oq_q;
  assign oR       = or_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32) with an expectation queue.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] iA = '0;
  logic [31:0] iB = '0;
  logic        abort = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] oQ, oR;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          t0;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign), .iA(iA), .iB(iB),
`ifdef SEQ_DIVIDER_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .oQ(oQ), .oR(oR), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result: plain SV division, with the zero-divisor and
  // signed-overflow cases written out explicitly.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    z = 1'b0;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Entered at a negedge; drives start for one cycle and queues the expectation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez);
    exp_t e;
    iA = a; iB = b; sign = s; start = 1'b1;
    e.q = eq; e.r = er; e.z = ez; e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    logic z;
    model(a, b, s, q, r, z);
    issue(a, b, s, q, r, z);
  endtask

  // Waits (bounded) for done, checking busy stays high until then, then
  // compares results and latency against the head of the queue.
  task automatic wait_check(input string tag);
    exp_t e;
    int n = 0;
    while (!done && n < 100) begin
      chk({tag, "_busy"}, busy, 1);
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_q"}, oQ, e.q);
    chk({tag, "_r"}, oR, e.r);
    chk({tag, "_dz"}, div_zero, e.z);
    chk({tag, "_latency"}, cyc - e.t0, e.z ? 2 : 34);
  endtask

  initial begin
    int seen;
    logic [31:0] ra, rb;
    logic rs;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", oQ, 0);
    chk("rst_r", oR, 0);
    chk("rst_dz", div_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // DIVU 100/7, plus single-cycle done pulse
    issue(100, 7, 1'b0, 14, 2, 1'b0);
    wait_check("divu_100_7");
    @(negedge clk);
    chk("done_pulse_one_cycle", done, 0);
    chk("q_held", oQ, 14);

    issue(32'hFFFF_FFF9, 2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    wait_check("div_m7_2");
    issue(7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 1, 1'b0);
    wait_check("div_7_m2");
    issue(32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
    wait_check("divu_max_1");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0, 1'b0);
    wait_check("div_overflow");
    issue(32'h8000_0000, 3, 1'b0, 32'h2AAA_AAAA, 2, 1'b0);
    wait_check("divu_msb_set");
    issue(32'h1234_5678, 0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    wait_check("div_zero");
    issue(32'hF000_0000, 0, 1'b1, 32'hFFFF_FFFF, 32'hF000_0000, 1'b1);
    wait_check("div_zero_neg");

    // Start while busy is ignored; operands changing mid-op have no effect
    issue(100, 7, 1'b0, 14, 2, 1'b0);
    repeat (4) @(negedge clk);
    iA = 9; iB = 3; sign = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; iA = 32'hDEAD_BEEF; iB = 0;
    wait_check("ignored_start");
    // Back-to-back start in the done cycle
    issue(9, 3, 1'b0, 3, 0, 1'b0);
    wait_check("b2b_start");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i == 5) ? 32'(($urandom & 32'hFF) + 1) : $urandom >> (i * 5);
      rs = i[0];
      issue_model(ra, rb, rs);
      wait_check($sformatf("rand%0d", i));
    end

    // Reset mid-operation aborts and clears results
    issue(100, 7, 1'b0, 14, 2, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_q", oQ, 0);
    chk("midrst_r", oR, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);

`ifdef SEQ_DIVIDER_ABORT_EN
    issue(50, 6, 1'b0, 8, 2, 1'b0);
    wait_check("pre_abort");
    issue(100, 7, 1'b0, 14, 2, 1'b0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    void'(sb.pop_back());
    chk("abort_busy", busy, 0);
    chk("abort_q_kept", oQ, 8);
    chk("abort_r_kept", oR, 2);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
